dm_port_arbiter: RTL and testbench

- Controller that shares the single-port word-wide data RAM between two requesters: the CPU MEM stage (port C) and the program-loader/DMA engine (port D).
- Arbitrates between the two requesters and sequences every access.
- Performs read-modify-write for byte and halfword stores (sb/sh), so the RAM stays a plain 32-bit word array.
- Sits between the pipeline MEM stage, the loader, and the DM word array.

---
 rtl/dm_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage (C) and the loader/DMA (D), with RMW for sb/sh.
// Define STORE_TRACE_EN to print every port-C RAM write.
module dm_port_arbiter #(
    parameter int AW      = 10,
    parameter int MAXWAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [1:0]    c_size,
    input  logic [31:0]   c_addr,
    input  logic [31:0]   c_wdata,
    input  logic [31:0]   c_pc,
    output logic          c_gnt,
    output logic          c_done,
    output logic [31:0]   c_rdata,
    output logic          c_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACC, MERGE, RESP} state_t;

    typedef struct packed {
        logic        own_d;
        logic        we;
        logic [1:0]  size;
        logic        mis;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;

    localparam int CW = $clog2(MAXWAIT + 1);

    state_t        state;
    req_t          cur, nxt;
    logic [CW-1:0] starve;
    logic          pick_c, pick_d;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data, merged;
    logic          unused_ok;

    // C wins ties until D has been passed over MAXWAIT times.
    always_comb begin
        pick_d    = d_req && (!c_req || starve == CW'(MAXWAIT));
        pick_c    = c_req && !pick_d;
        nxt.own_d = pick_d;
        nxt.we    = pick_d ? d_we    : c_we;
        nxt.size  = pick_d ? d_size  : c_size;
        nxt.addr  = pick_d ? d_addr  : c_addr;
        nxt.wdata = pick_d ? d_wdata : c_wdata;
        nxt.pc    = pick_d ? 32'h0   : c_pc;
        nxt.mis   = (nxt.size == 2'd3) ||
                    (nxt.size == 2'd1 && nxt.addr[0]) ||
                    (nxt.size == 2'd2 && nxt.addr[1:0] != 2'b00);
    end

    // Sub-word store merge: replicate the store data across lanes, pick by lane enable.
    always_comb begin
        merged    = ram_rdata;
        lane_en   = cur.addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cur.wdata[15:0]}};
        if (cur.size == 2'd0) begin
            lane_en   = 4'b0001 << cur.addr[1:0];
            lane_data = {4{cur.wdata[7:0]}};
        end
        for (int i = 0; i < 4; i++)
            if (lane_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end

    assign unused_ok = ^{cur.pc, cur.addr};

    // The RAM address is driven from the grant edge so read data is ready one cycle into the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            starve    <= '0;
            cur       <= '0;
            c_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            c_done    <= 1'b0;
            d_done    <= 1'b0;
            c_err     <= 1'b0;
            d_err     <= 1'b0;
            c_rdata   <= '0;
            d_rdata   <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            c_gnt  <= 1'b0;
            d_gnt  <= 1'b0;
            c_done <= 1'b0;
            d_done <= 1'b0;
            c_err  <= 1'b0;
            d_err  <= 1'b0;
            ram_we <= 1'b0;
            if (!d_req || (state == IDLE && pick_d))
                starve <= '0;
            else if (state == IDLE && starve != CW'(MAXWAIT))
                starve <= starve + CW'(1);
            case (state)
                IDLE: if (pick_c || pick_d) begin
                    c_gnt    <= pick_c;
                    d_gnt    <= pick_d;
                    cur      <= nxt;
                    ram_addr <= nxt.addr[AW+1:2];
                    state    <= ACC;
                end
                ACC: begin
                    if (cur.mis || (cur.we && cur.size == 2'd2)) begin
                        if (!cur.mis) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= cur.wdata;
                        end
                        c_done <= !cur.own_d;
                        d_done <= cur.own_d;
                        c_err  <= cur.mis && !cur.own_d;
                        d_err  <= cur.mis && cur.own_d;
                        state  <= IDLE;
                    end else begin
                        state <= cur.we ? MERGE : RESP;
                    end
                end
                MERGE: begin
                    ram_we    <= 1'b1;
                    ram_wdata <= merged;
                    c_done    <= !cur.own_d;
                    d_done    <= cur.own_d;
                    state     <= IDLE;
                end
                RESP: begin
                    if (cur.own_d) d_rdata <= ram_rdata;
                    else           c_rdata <= ram_rdata;
                    c_done <= !cur.own_d;
                    d_done <= cur.own_d;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STORE_TRACE_EN
    always @(posedge clk)
        if (ram_we && !cur.own_d)
            $display("%d@%h: *%h <= %h", $time, cur.pc, {cur.addr[31:2], 2'b00}, ram_wdata);
`else
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: drivers queue expected responses/writes, a negedge monitor checks them.
module tb_dm_port_arbiter;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [1:0]    c_size, d_size;
    logic [31:0]   c_addr, c_wdata, c_pc, d_addr, d_wdata;
    logic          c_gnt, c_done, c_err, d_gnt, d_done, d_err;
    logic [31:0]   c_rdata, d_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [31:0]   mem [0:1023] = '{default: 32'h0};

    typedef struct { logic err; logic ld; logic [31:0] rd; int lat; } resp_t;
    typedef struct { logic [AW-1:0] a; logic [31:0] w; } wr_t;

    resp_t rq0[$], rq1[$];
    wr_t   wq[$];
    wr_t   we_exp;
    int    gq[$];
    int    total = 0, bad = 0, cyc = 0;
    int    gnt_cyc[2], done_cyc[2];

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(AW), .MAXWAIT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // synchronous-read word RAM
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_resp(input int p);
        resp_t e;
        if ((p == 1 ? rq1.size() : rq0.size()) == 0) begin
            total++; bad++;
            $display("FAIL stray done on port %0d at cycle %0d", p, cyc);
        end else begin
            if (p == 1) e = rq1.pop_front();
            else        e = rq0.pop_front();
            chk($sformatf("p%0d err", p), 32'(p == 1 ? d_err : c_err), 32'(e.err));
            if (e.ld) chk($sformatf("p%0d rdata", p), p == 1 ? d_rdata : c_rdata, e.rd);
            chk($sformatf("p%0d latency", p), 32'(cyc - gnt_cyc[p]), 32'(e.lat));
        end
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL stray ram write addr=%h data=%h", ram_addr, ram_wdata);
            end else begin
                we_exp = wq.pop_front();
                chk("ram_addr", 32'(ram_addr), 32'(we_exp.a));
                chk("ram_wdata", ram_wdata, we_exp.w);
            end
        end
        if (c_gnt === 1'b1 || d_gnt === 1'b1) begin
            chk("single grant", 32'(c_gnt & d_gnt), 32'h0);
            if (c_gnt) gnt_cyc[0] = cyc;
            if (d_gnt) gnt_cyc[1] = cyc;
            if (gq.size() > 0) chk("grant order", 32'(d_gnt), 32'(gq.pop_front()));
        end
        if (c_done === 1'b1) begin done_cyc[0] = cyc; chk_resp(0); end
        if (d_done === 1'b1) begin done_cyc[1] = cyc; chk_resp(1); end
    end

    // Issue one transaction; caller is #1 after a posedge. Returns #1 after the done edge.
    task automatic txn(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd);
        resp_t e;
        int    n;
        e.err = err;
        e.ld  = !we && !err;
        e.rd  = rd;
        e.lat = (err || (we && sz == 2'd2)) ? 1 : 2;
        if (p == 1) begin
            rq1.push_back(e);
            d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            rq0.push_back(e);
            c_req = 1'b1; c_we = we; c_size = sz; c_addr = a; c_wdata = wd; c_pc = 32'h100 + a;
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(p == 1 ? d_gnt : c_gnt) && n < 200);
        if (!(p == 1 ? d_gnt : c_gnt)) begin
            total++; bad++;
            $display("FAIL p%0d grant timeout addr=%h", p, a);
        end
        if (p == 1) d_req = 1'b0;
        else        c_req = 1'b0;
        n = 0;
        while (!(p == 1 ? d_done : c_done) && n < 200) begin @(posedge clk); #1; n++; end
        if (!(p == 1 ? d_done : c_done)) begin
            total++; bad++;
            $display("FAIL p%0d done timeout addr=%h", p, a);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] w);
        wr_t x;
        x.a = a; x.w = w;
        wq.push_back(x);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " gnt/done/err"}, {26'b0, c_gnt, c_done, c_err, d_gnt, d_done, d_err}, 32'h0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, " ram_we"}, 32'(ram_we), 32'h0);
        chk({tag, " ram_wdata"}, ram_wdata, 32'h0);
        chk({tag, " c_rdata"}, c_rdata, 32'h0);
        chk({tag, " d_rdata"}, d_rdata, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        c_req = 0; c_we = 0; c_size = 0; c_addr = 0; c_wdata = 0; c_pc = 0;
        d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outs("reset");
        reset = 1'b0;

        // word store/load round trip
        exp_wr(10'h004, 32'hDEADBEEF);
        txn(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 0);
        txn(0, 0, 2'd2, 32'h10, 0, 0, 32'hDEADBEEF);

        // sub-word read-modify-write
        exp_wr(10'h008, 32'h11223344);
        txn(0, 1, 2'd2, 32'h20, 32'h11223344, 0, 0);
        exp_wr(10'h008, 32'hABCD3344);
        txn(0, 1, 2'd1, 32'h22, 32'h0000ABCD, 0, 0);
        exp_wr(10'h008, 32'hABCD7744);
        txn(0, 1, 2'd0, 32'h21, 32'h00000077, 0, 0);
        txn(0, 0, 2'd2, 32'h20, 0, 0, 32'hABCD7744);
        exp_wr(10'h008, 32'hEECD7744);
        txn(0, 1, 2'd0, 32'h23, 32'h123456EE, 0, 0);
        exp_wr(10'h008, 32'hEECD5566);
        txn(0, 1, 2'd1, 32'h20, 32'hFFFF5566, 0, 0);
        txn(0, 0, 2'd2, 32'h20, 0, 0, 32'hEECD5566);

        // misaligned / reserved size: error at T+1, no write
        txn(0, 1, 2'd1, 32'h23, 32'h0000BEEF, 1, 0);
        txn(0, 0, 2'd2, 32'h26, 0, 1, 0);
        txn(0, 1, 2'd3, 32'h24, 32'hFFFFFFFF, 1, 0);
        txn(1, 0, 2'd2, 32'h42, 0, 1, 0);
        txn(1, 1, 2'd1, 32'h21, 32'h00001111, 1, 0);
        txn(0, 0, 2'd2, 32'h20, 0, 0, 32'hEECD5566);

        // upper address bits wrap
        exp_wr(10'h004, 32'hCAFEF00D);
        txn(0, 1, 2'd2, 32'h1010, 32'hCAFEF00D, 0, 0);
        txn(0, 0, 2'd2, 32'h10, 0, 0, 32'hCAFEF00D);

        // starvation: D wins the fifth arbitration
        gq = {0, 0, 0, 0, 1, 0, 0};
        fork
            begin
                for (int i = 0; i < 6; i++) txn(0, 0, 2'd2, 32'h20, 0, 0, 32'hEECD5566);
            end
            txn(1, 0, 2'd2, 32'h10, 0, 0, 32'hCAFEF00D);
        join

        // simultaneous requests with a cleared counter: C first, D right after c_done
        gq = {0, 1};
        exp_wr(10'h010, 32'h55AA55AA);
        fork
            txn(0, 0, 2'd2, 32'h20, 0, 0, 32'hEECD5566);
            txn(1, 1, 2'd2, 32'h40, 32'h55AA55AA, 0, 0);
        join
        chk("d grant after c_done", 32'(gnt_cyc[1] - done_cyc[0]), 32'd1);
        txn(1, 0, 2'd2, 32'h40, 0, 0, 32'h55AA55AA);
        exp_wr(10'h010, 32'h11AA55AA);
        txn(1, 1, 2'd0, 32'h43, 32'h00000011, 0, 0);
        txn(0, 0, 2'd2, 32'h40, 0, 0, 32'h11AA55AA);

        // reset while the sh merge is pending: no write, no done
        c_req = 1'b1; c_we = 1'b1; c_size = 2'd1; c_addr = 32'h40; c_wdata = 32'h00009999; c_pc = 32'h140;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!c_gnt && n < 200);
        if (!c_gnt) begin
            total++; bad++;
            $display("FAIL reset-test grant timeout");
        end
        c_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle_outs("mid reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post reset ram_we", 32'(ram_we), 32'h0);
        txn(0, 0, 2'd2, 32'h40, 0, 0, 32'h11AA55AA);

        repeat (3) @(posedge clk);
        #1;
        chk("c resp queue drained", 32'(rq0.size()), 32'h0);
        chk("d resp queue drained", 32'(rq1.size()), 32'h0);
        chk("write queue drained", 32'(wq.size()), 32'h0);
        chk("grant queue drained", 32'(gq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
